// File: rtl/fc_bin_pkg.sv
// Shared types and helpers for the binary fully-connected neuron engine.
// Bank/FSM state encodings, the ±1 bit constants and a constant-safe clog2.
package fc_bin_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        ACTIVE = 2'd2
    } bank_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    localparam logic BIT_POS = 1'b1;
    localparam logic BIT_NEG = 1'b0;

    function automatic int fc_clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fc_bin_wbank.sv
// One weight bank: bit-serial write at (beat, channel), one CH-bit beat read.
// Contents need no reset; validity is tracked by the bank state in the top.
module fc_bin_wbank
    import fc_bin_pkg::*;
#(
    parameter int CH  = 12,
    parameter int LEN = 12,
    parameter int TW  = (LEN > 1) ? fc_clog2(LEN) : 1,
    parameter int CW  = (CH > 1) ? fc_clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [TW-1:0] wr_beat,
    input  logic [CW-1:0] wr_ch,
    input  logic          wbit,
    input  logic [TW-1:0] rd_beat,
    output logic [CH-1:0] rd_data
);

    logic [CH-1:0] mem [LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_beat][wr_ch] <= wbit;
        end
    end

    // Read is combinational so the accepting edge sees the current beat's weights.
    assign rd_data = mem[rd_beat];

endmodule

// File: rtl/fc_bin_dbuf.sv
// Binary (XNOR-popcount) fully-connected neuron with double-buffered serial
// weights, threshold output, weight reuse and synchronous frame abort.
module fc_bin_dbuf
    import fc_bin_pkg::*;
#(
    parameter int CH    = 12,
    parameter int LEN   = 12,
    parameter int ACC_W = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    weight,
    input  logic                    weight_en,
    output logic                    w_ready,
    output logic                    w_ovf,
    input  logic                    ivalid,
    input  logic [CH-1:0]           din,
    output logic                    iready,
    input  logic                    clr,
    input  logic                    w_keep,
    input  logic signed [ACC_W-1:0] thresh,
    output logic                    ovalid,
    output logic signed [ACC_W-1:0] dout,
    output logic                    dbin
);

    localparam int TW = (LEN > 1) ? fc_clog2(LEN) : 1;
    localparam int CW = (CH > 1) ? fc_clog2(CH) : 1;
    localparam int PW = fc_clog2(CH + 1);
    localparam logic [TW-1:0] T_LAST = TW'(LEN - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CH - 1);
    localparam logic signed [ACC_W-1:0] CH_S = ACC_W'(CH);

    if (ACC_W < fc_clog2(CH * LEN) + 2) begin : g_acc_w_check
        $error("fc_bin_dbuf: ACC_W too narrow for CH*LEN");
    end

    bank_state_t bank_reg [2];
    bank_state_t bank_next [2];
    fsm_state_t  fsm_reg, fsm_next;
    logic        ld_ptr_reg, ld_ptr_next;
    logic [TW-1:0] ld_t_reg, ld_t_next;
    logic [CW-1:0] ld_c_reg, ld_c_next;
    logic [TW-1:0] t_reg, t_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic signed [ACC_W-1:0] dout_reg, dout_next;
    logic        dbin_reg, dbin_next;
    logic        ovalid_reg, ovalid_next;
    logic        w_ovf_reg, w_ovf_next;

    logic          has_active, act_sel, ld_sel;
    logic          wr_fire, ld_last, beat_fire, beat_last;
    logic [CH-1:0] rd_data [2];
    logic [CH-1:0] w_beat, match;
    logic [PW-1:0] pop;
    logic signed [ACC_W-1:0] contrib, sum;

    assign has_active = (bank_reg[0] == ACTIVE) || (bank_reg[1] == ACTIVE);
    assign act_sel    = (bank_reg[1] == ACTIVE);
    assign ld_sel     = has_active ? ~act_sel : ld_ptr_reg;
    assign w_ready    = (bank_reg[ld_sel] == EMPTY);
    assign wr_fire    = weight_en & w_ready;
    assign ld_last    = (ld_t_reg == T_LAST) && (ld_c_reg == C_LAST);
    assign iready     = (fsm_reg == RUN);
    assign beat_fire  = ivalid & iready & ~clr;
    assign beat_last  = (t_reg == T_LAST);

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        fc_bin_wbank #(.CH(CH), .LEN(LEN), .TW(TW), .CW(CW)) u_bank (
            .clk     (clk),
            .we      (wr_fire && (ld_sel == 1'(gi))),
            .wr_beat (ld_t_reg),
            .wr_ch   (ld_c_reg),
            .wbit    (weight),
            .rd_beat (t_reg),
            .rd_data (rd_data[gi])
        );
    end

    assign w_beat = rd_data[act_sel];

    always_comb begin
        pop = '0;
        for (int c = 0; c < CH; c++) begin
            match[c] = (din[c] == w_beat[c]) ? BIT_POS : BIT_NEG;
            if (match[c] == BIT_POS) begin
                pop = pop + 1'b1;
            end
        end
        contrib = ACC_W'({pop, 1'b0}) - CH_S;
        sum     = acc_reg + contrib;
    end

    // Bank bookkeeping: fill, release (with zero-bubble hand-over) and promotion.
    always_comb begin
        bank_next   = bank_reg;
        ld_ptr_next = ld_ptr_reg;
        ld_t_next   = ld_t_reg;
        ld_c_next   = ld_c_reg;
        w_ovf_next  = w_ovf_reg | (weight_en & ~w_ready);
        if (wr_fire) begin
            if (ld_last) begin
                bank_next[ld_sel] = FULL;
                ld_t_next   = '0;
                ld_c_next   = '0;
                ld_ptr_next = ~ld_sel;
            end else if (ld_c_reg == C_LAST) begin
                ld_c_next = '0;
                ld_t_next = ld_t_reg + 1'b1;
            end else begin
                ld_c_next = ld_c_reg + 1'b1;
            end
        end
        // Hand-over looks at the registered state, so a bank filling on this
        // same edge waits one more edge instead of double-promoting.
        if (beat_fire && beat_last && !w_keep) begin
            bank_next[act_sel] = EMPTY;
            if (bank_reg[~act_sel] == FULL) begin
                bank_next[~act_sel] = ACTIVE;
            end
        end
        if (!has_active) begin
            if (bank_reg[~ld_ptr_reg] == FULL) begin
                bank_next[~ld_ptr_reg] = ACTIVE;
            end else if (bank_reg[ld_ptr_reg] == FULL) begin
                bank_next[ld_ptr_reg] = ACTIVE;
            end
        end
        fsm_next = ((bank_next[0] == ACTIVE) || (bank_next[1] == ACTIVE)) ? RUN : IDLE;
    end

    always_comb begin
        acc_next    = acc_reg;
        t_next      = t_reg;
        dout_next   = dout_reg;
        dbin_next   = dbin_reg;
        ovalid_next = 1'b0;
        unique case (fsm_reg)
            RUN: begin
                if (clr) begin
                    acc_next = '0;
                    t_next   = '0;
                end else if (beat_fire) begin
                    if (beat_last) begin
                        acc_next    = '0;
                        t_next      = '0;
                        dout_next   = sum;
                        dbin_next   = (sum >= thresh);
                        ovalid_next = 1'b1;
                    end else begin
                        acc_next = sum;
                        t_next   = t_reg + 1'b1;
                    end
                end
            end
            default: begin
                acc_next = acc_reg;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                bank_reg[b] <= EMPTY;
            end
            fsm_reg    <= IDLE;
            ld_ptr_reg <= 1'b0;
            ld_t_reg   <= '0;
            ld_c_reg   <= '0;
            t_reg      <= '0;
            acc_reg    <= '0;
            dout_reg   <= '0;
            dbin_reg   <= 1'b0;
            ovalid_reg <= 1'b0;
            w_ovf_reg  <= 1'b0;
        end else begin
            bank_reg   <= bank_next;
            fsm_reg    <= fsm_next;
            ld_ptr_reg <= ld_ptr_next;
            ld_t_reg   <= ld_t_next;
            ld_c_reg   <= ld_c_next;
            t_reg      <= t_next;
            acc_reg    <= acc_next;
            dout_reg   <= dout_next;
            dbin_reg   <= dbin_next;
            ovalid_reg <= ovalid_next;
            w_ovf_reg  <= w_ovf_next;
        end
    end

    assign dout   = dout_reg;
    assign dbin   = dbin_reg;
    assign ovalid = ovalid_reg;
    assign w_ovf  = w_ovf_reg;

endmodule

// File: tb/tb_fc_bin_dbuf.sv
// Scoreboard bench for fc_bin_dbuf: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every ovalid pulse.
module tb_fc_bin_dbuf;

    localparam int CH    = 12;
    localparam int LEN   = 12;
    localparam int ACC_W = 16;
    localparam int NB    = CH * LEN;

    logic clk = 1'b0;
    logic rstn;
    logic weight, weight_en, w_ready, w_ovf;
    logic ivalid, iready, clr, w_keep;
    logic [CH-1:0] din;
    logic signed [ACC_W-1:0] thresh;
    logic ovalid, dbin;
    logic signed [ACC_W-1:0] dout;

    fc_bin_dbuf #(.CH(CH), .LEN(LEN), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .weight    (weight),
        .weight_en (weight_en),
        .w_ready   (w_ready),
        .w_ovf     (w_ovf),
        .ivalid    (ivalid),
        .din       (din),
        .iready    (iready),
        .clr       (clr),
        .w_keep    (w_keep),
        .thresh    (thresh),
        .ovalid    (ovalid),
        .dout      (dout),
        .dbin      (dbin)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        bit b;
    } exp_t;

    exp_t sb[$];
    int   ov_cyc[$];
    int   cyc = 0;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   last_beat_cyc = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        vec_cnt++;
        if (act != req) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int d, input bit b);
        exp_t e;
        e.d = d;
        e.b = b;
        sb.push_back(e);
    endtask

    // Monitor: one line per result, compared against the scoreboard head.
    always @(negedge clk) begin
        if (rstn && ovalid) begin
            ov_cyc.push_back(cyc);
            check("ovalid_width", int'(prev_ov), 0);
            if (sb.size() == 0) begin
                check("unexpected_ovalid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("result cycle %0d: dout=%0d dbin=%0d (want %0d/%0d)",
                         cyc, $signed(dout), dbin, e.d, e.b);
                check("dout", int'($signed(dout)), e.d);
                check("dbin", int'(dbin), int'(e.b));
            end
        end
        prev_ov = rstn && ovalid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // pat: 0 = all -1, 1 = all +1, 2 = +1 on even bit index
    task automatic load_bits(input int pat, input int n);
        for (int k = 0; k < n; k++) begin
            weight_en = 1'b1;
            weight    = (pat == 1) || (pat == 2 && (k % 2) == 0);
            step();
        end
        weight_en = 1'b0;
        weight    = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!iready && n < 50) begin
            step();
            n++;
        end
        if (!iready) check("iready_timeout", 0, 1);
    endtask

    task automatic frame(input logic [CH-1:0] d, input int nbeats, input int gap);
        for (int i = 0; i < nbeats; i++) begin
            wait_ready();
            ivalid = 1'b1;
            din    = d;
            step();
            last_beat_cyc = cyc;
            ivalid = 1'b0;
            for (int g = 0; g < gap; g++) step();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dropped;
        rstn = 1'b0; weight = 1'b0; weight_en = 1'b0; ivalid = 1'b0;
        din = '0; clr = 1'b0; w_keep = 1'b0; thresh = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        step();

        check("rst_dout", int'(dout), 0);
        check("rst_dbin", int'(dbin), 0);
        check("rst_ovalid", int'(ovalid), 0);
        check("rst_iready", int'(iready), 0);
        check("rst_w_ready", int'(w_ready), 1);
        check("rst_w_ovf", int'(w_ovf), 0);

        // All +1 weights against all-ones and all-zeros input.
        load_bits(1, NB);
        push(144, 1);
        frame(12'hFFF, LEN, 0);
        drain();
        load_bits(1, NB);
        push(-144, 0);
        frame(12'h000, LEN, 0);
        drain();
        repeat (4) step();
        check("dout_hold", int'($signed(dout)), -144);

        // Alternating weights: zero sum, threshold decides dbin.
        thresh = 16'sd1;
        load_bits(2, NB);
        push(0, 0);
        frame(12'hFFF, LEN, 0);
        drain();
        thresh = 16'sd0;
        load_bits(2, NB);
        push(0, 1);
        frame(12'hFFF, LEN, 0);
        drain();

        // Double buffering: back-to-back frames with zero bubble.
        load_bits(1, NB);
        wait_ready();
        load_bits(0, NB);
        check("w_ready_both_loaded", int'(w_ready), 0);
        push(144, 1);
        push(-144, 0);
        dropped = 0;
        for (int i = 0; i < 2 * LEN; i++) begin
            if (!iready) dropped = 1;
            ivalid = 1'b1;
            din    = 12'hFFF;
            step();
        end
        ivalid = 1'b0;
        drain();
        check("b2b_iready_drop", dropped, 0);
        check("b2b_gap", ov_cyc[ov_cyc.size()-1] - ov_cyc[ov_cyc.size()-2], LEN);

        // Weight reuse across three frames.
        w_keep = 1'b1;
        load_bits(1, NB);
        for (int f = 0; f < 3; f++) begin
            push(144, 1);
            frame(12'hFFF, LEN, 0);
        end
        drain();
        check("keep_iready", int'(iready), 1);
        check("keep_w_ready", int'(w_ready), 1);
        load_bits(1, NB);
        check("keep_w_ready_after_load", int'(w_ready), 0);
        w_keep = 1'b0;

        // Abort after five beats; the clr-cycle beat must be dropped.
        frame(12'h000, 5, 0);
        clr = 1'b1; ivalid = 1'b1; din = 12'hFFF;
        step();
        clr = 1'b0; ivalid = 1'b0;
        push(144, 1);
        frame(12'hFFF, LEN, 0);
        drain();
        check("clr_latency", ov_cyc[ov_cyc.size()-1], last_beat_cyc);

        // Gapped input stream.
        push(144, 1);
        frame(12'hFFF, LEN, 3);
        drain();
        check("gap_latency", ov_cyc[ov_cyc.size()-1], last_beat_cyc);

        // Overflow: extra bits with both banks occupied.
        load_bits(1, NB);
        load_bits(1, NB);
        check("ovf_w_ready", int'(w_ready), 0);
        load_bits(1, 10);
        check("ovf_sticky", int'(w_ovf), 1);
        push(144, 1);
        frame(12'hFFF, LEN, 0);
        drain();
        check("ovf_still_set", int'(w_ovf), 1);

        // Reset mid-frame at beat 6.
        frame(12'hFFF, 6, 0);
        rstn = 1'b0;
        step();
        check("mid_rst_dout", int'(dout), 0);
        check("mid_rst_dbin", int'(dbin), 0);
        check("mid_rst_ovalid", int'(ovalid), 0);
        check("mid_rst_iready", int'(iready), 0);
        check("mid_rst_w_ready", int'(w_ready), 1);
        check("mid_rst_w_ovf", int'(w_ovf), 0);
        step();
        rstn = 1'b1;
        step();
        load_bits(1, NB);
        push(144, 1);
        frame(12'hFFF, LEN, 0);
        drain();

        repeat (3) step();
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
